issue_select: RTL and testbench
===============================

Name: issue_select

Overview:
- Select-side counterpart of the reservation-station wakeup block. Consumes the per-entry request vector and picks at most one entry per cycle with rotating (round-robin) priority.
- Returns the grant to wakeup (grant_en/grant_index) so the entry is marked selected.
- Holds the winner in an issue register toward execute, with a valid/ready handshake.
- Tracks per-FU occupancy so non-pipelined units are not over-issued.

Parameters:
RS_ENTRIES, 16, number of reservation-station entries; power of two, >= 2
NUM_FUS, 4, number of functional units; power of two, >= 2
OCC_W, 8, width of per-entry FU occupancy field

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
request_vector  input  RS_ENTRIES  bit j = entry j ready and not yet selected
entry_fu  input  RS_ENTRIES*log2(NUM_FUS)  FU id of entry j at slice [j*FW +: FW]
entry_occ  input  RS_ENTRIES*OCC_W  cycles entry j occupies its FU; 0 treated as 1
flush  input  1  pipeline flush
grant_en  output  1  combinational grant pulse to wakeup
grant_index  output  log2(RS_ENTRIES)  granted entry
issue_valid  output  1  issue register holds an instruction
issue_index  output  log2(RS_ENTRIES)  RS entry being issued
issue_fu  output  log2(NUM_FUS)  target FU
issue_ready  input  1  execute accepts issue this cycle

Behaviour:
- Reset (rst=1 at posedge):
  - rr_ptr=0, all fu_cnt=0, issue_valid=0, issue_index=0, issue_fu=0.
  - grant_en is 0 while rst=1.
- FU busy state:
  - fu_busy[f] = (fu_cnt[f] != 0).
  - Eligible: elig[j] = request_vector[j] & ~fu_busy[entry_fu[j]].
- Slot availability: slot_free = ~issue_valid | issue_ready.
- Grant (combinational, same cycle as request):
  - grant_en = slot_free & ~flush & ~rst & (elig != 0).
  - grant_index = first set bit of elig searching upward from rr_ptr, wrapping RS_ENTRIES-1 -> 0.
  - grant_index holds its last value when grant_en=0; it is never undefined.
- Updates on a grant (posedge with grant_en=1):
  - issue_valid<=1; issue_index<=grant_index; issue_fu<=entry_fu[grant_index].
  - rr_ptr<=(grant_index+1) mod RS_ENTRIES; natural wrap by width.
  - fu_cnt[issue FU]<=max(entry_occ,1)-1.
  - An occupancy of 1 leaves the FU immediately free next cycle (fully pipelined).
- Handshake:
  - issue fires when issue_valid & issue_ready.
  - Fire without a new grant: issue_valid<=0.
  - Fire with a new grant in the same cycle: the register reloads, no bubble.
  - While issue_valid & ~issue_ready: no grants; issue_index and issue_fu are stable.
- Counters:
  - Each fu_cnt[f] != 0 decrements by 1 per cycle, except in a cycle where it is reloaded by a grant.
  - Reload only occurs when the counter is 0, because busy FUs are ineligible.
- Latency: request visible -> grant same cycle -> issue_valid next cycle.
- Flush (priority below rst, above all else):
  - issue_valid<=0, all fu_cnt<=0, grant_en forced 0.
  - rr_ptr is unchanged.
- Boundaries:
  - request_vector all zero -> no grant, state unchanged except counter decrement.
  - Single requester at rr_ptr-1 -> found after full wrap.
  - All eligible requesters share one busy FU -> no grant until the counter reaches 0.
  - Request bits for non-eligible entries are ignored, not queued.

Optional Feature:
- Macro: ISSUE_SELECT_STATS_EN.
- When defined:
  - Adds outputs stat_grants [31:0] and stat_stalls [31:0].
  - stat_grants increments each cycle with grant_en=1.
  - stat_stalls increments each cycle with request_vector!=0 and grant_en=0 and flush=0.
  - Both are cleared by rst only, not by flush, and wrap at 2^32.
- When not defined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset then request_vector=16'h0000 for 5 cycles -> grant_en=0, issue_valid=0, rr_ptr=0.
- Round-robin fairness:
  - Stimulus: request_vector=16'h8001 held, issue_ready=1, all occ=1, distinct FUs.
  - Response: grant_index sequence 0,15,0,15.
  - Response: issue_valid high from cycle 1, no bubbles.
- Backpressure:
  - Stimulus: grant entry 3, then issue_ready=0 for 4 cycles with request_vector=16'h0030.
  - Response: issue_index stays 3, no grant_en for those 4 cycles.
  - Response: on issue_ready=1, entry 4 is granted the same cycle.
- Non-pipelined FU:
  - Stimulus: entries 2,5 both on FU1 with occ=3, issue_ready=1.
  - Response: entry 2 is granted at t0; entry 5 is granted at t3, not earlier.
- Flush:
  - Stimulus: flush with issue_valid=1 and fu_cnt[1]=2.
  - Response: next cycle issue_valid=0, FU1 eligible, no grant during the flush cycle.
- Wrap:
  - Stimulus: rr_ptr=15, request_vector=16'h0004.
  - Response: grant_index=2, rr_ptr becomes 3.
  - With ISSUE_SELECT_STATS_EN: stat_grants=1 after this single grant from reset.

Source files
------------

// File: rtl/issue_select.sv
// -----------------------------------------------------------------------------
// issue_select
//
// Select stage of the reservation station. Each cycle it picks at most one
// ready entry using rotating (round-robin) priority. The grant goes back to
// wakeup so that entry is marked selected. The winner is held in an issue
// register that drains toward execute through a valid/ready handshake.
// A per-FU occupancy counter keeps non-pipelined units from being over-issued.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   request_vector  bit j = entry j ready and not yet selected
//   entry_fu        FU id of entry j at [j*FW +: FW]
//   entry_occ       FU occupancy of entry j at [j*OCC_W +: OCC_W] (0 acts as 1)
//   flush           pipeline flush: empties the issue register and frees all FUs
//   grant_en        combinational grant pulse to wakeup
//   grant_index     granted entry; holds its last value when grant_en=0
//   issue_valid     issue register holds an instruction
//   issue_index     RS entry being issued
//   issue_fu        target FU
//   issue_ready     execute accepts the issue this cycle
//
// Optional feature (macro ISSUE_SELECT_STATS_EN):
//   stat_grants     count of cycles with a grant
//   stat_stalls     count of cycles with requests but no grant and no flush
//   Both counters are cleared only by rst and wrap at 2^32.
// -----------------------------------------------------------------------------
module issue_select #(
  parameter int RS_ENTRIES = 16,
  parameter int NUM_FUS    = 4,
  parameter int OCC_W      = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [RS_ENTRIES-1:0]                  request_vector,
  input  logic [RS_ENTRIES*$clog2(NUM_FUS)-1:0]  entry_fu,
  input  logic [RS_ENTRIES*OCC_W-1:0]            entry_occ,
  input  logic                                   flush,
  output logic                                   grant_en,
  output logic [$clog2(RS_ENTRIES)-1:0]          grant_index,
  output logic                                   issue_valid,
  output logic [$clog2(RS_ENTRIES)-1:0]          issue_index,
  output logic [$clog2(NUM_FUS)-1:0]             issue_fu,
  input  logic                                   issue_ready
`ifdef ISSUE_SELECT_STATS_EN
  ,
  output logic [31:0]                            stat_grants,
  output logic [31:0]                            stat_stalls
`endif
);

  localparam int FW = $clog2(NUM_FUS);
  localparam int IW = $clog2(RS_ENTRIES);

  logic [FW-1:0]         fu_of    [RS_ENTRIES];
  logic [OCC_W-1:0]      occ_of   [RS_ENTRIES];
  logic [OCC_W-1:0]      fu_cnt   [NUM_FUS];
  logic [NUM_FUS-1:0]    fu_busy;
  logic [RS_ENTRIES-1:0] elig;

  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    last_grant;
  logic [IW-1:0]    scan_idx;
  logic [IW-1:0]    sel_index;
  logic             sel_found;
  logic             slot_free;
  logic [FW-1:0]    grant_fu;
  logic [OCC_W-1:0] grant_occ;
  logic [OCC_W-1:0] reload_val;

  // Unpack the per-entry fields once so the rest of the logic can index by entry.
  always_comb begin
    for (int j = 0; j < RS_ENTRIES; j++) begin
      fu_of[j]  = entry_fu[j*FW +: FW];
      occ_of[j] = entry_occ[j*OCC_W +: OCC_W];
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FUS; f++) begin
      fu_busy[f] = (fu_cnt[f] != '0);
    end
  end

  always_comb begin
    for (int j = 0; j < RS_ENTRIES; j++) begin
      elig[j] = request_vector[j] & ~fu_busy[fu_of[j]];
    end
  end

  // Round-robin scan: walk upward from rr_ptr. The IW-bit index wraps naturally
  // from RS_ENTRIES-1 back to 0. The first eligible entry wins.
  // NOTE: every variable written in this block gets a default first, so no
  // path can leave a value held and infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_index = rr_ptr;
    scan_idx  = rr_ptr;
    for (int k = 0; k < RS_ENTRIES; k++) begin
      scan_idx = rr_ptr + IW'(k);
      if (!sel_found && elig[scan_idx]) begin
        sel_found = 1'b1;
        sel_index = scan_idx;
      end
    end
  end

  assign slot_free   = ~issue_valid | issue_ready;
  assign grant_en    = slot_free & ~flush & ~rst & sel_found;
  // When there is no grant, present the previous winner so the index is never X.
  assign grant_index = grant_en ? sel_index : last_grant;
  assign grant_fu    = fu_of[grant_index];
  assign grant_occ   = occ_of[grant_index];
  // The counter holds the number of extra busy cycles. An occupancy of 0 or 1
  // leaves the FU free on the next cycle.
  assign reload_val  = (grant_occ == '0) ? '0 : grant_occ - OCC_W'(1);

  // NOTE: all state uses non-blocking assignments so every flop samples the
  // pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr      <= '0;
      last_grant  <= '0;
      issue_valid <= 1'b0;
      issue_index <= '0;
      issue_fu    <= '0;
      // NOTE: the occupancy counters are a small flop array, not RAM. They must
      // be reset, because a stale non-zero count would block an FU forever.
      for (int f = 0; f < NUM_FUS; f++) fu_cnt[f] <= '0;
    end else if (flush) begin
      issue_valid <= 1'b0;
      for (int f = 0; f < NUM_FUS; f++) fu_cnt[f] <= '0;
    end else begin
      // A busy FU is ineligible, so a reload only ever lands on a zero counter.
      for (int f = 0; f < NUM_FUS; f++) begin
        if (grant_en && grant_fu == FW'(f)) fu_cnt[f] <= reload_val;
        else if (fu_cnt[f] != '0)           fu_cnt[f] <= fu_cnt[f] - OCC_W'(1);
      end
      if (grant_en) begin
        issue_valid <= 1'b1;
        issue_index <= grant_index;
        issue_fu    <= grant_fu;
        rr_ptr      <= grant_index + IW'(1);
        last_grant  <= grant_index;
      end else if (issue_valid && issue_ready) begin
        issue_valid <= 1'b0;
      end
    end
  end

`ifdef ISSUE_SELECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (grant_en) stat_grants <= stat_grants + 32'd1;
      if ((request_vector != '0) && !grant_en && !flush)
        stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_select.sv
// -----------------------------------------------------------------------------
// tb_issue_select
//
// Self-checking bench for issue_select (16 entries, 4 FUs, 8-bit occupancy).
// A behavioural model tracks the pointer, the per-FU busy time and the issue
// slot as plain integers, and every cycle it is compared with the DUT. On top
// of that, a table of hand-derived cycles and a few hand-written sequences
// pin down specific grant orders and corner cases.
// -----------------------------------------------------------------------------
module tb_issue_select;

  localparam int N  = 16;
  localparam int NF = 4;
  localparam int FW = 2;
  localparam int OW = 8;

  logic          clk;
  logic          rst;
  logic [N-1:0]  request_vector;
  logic [N*FW-1:0] entry_fu;
  logic [N*OW-1:0] entry_occ;
  logic          flush;
  logic          grant_en;
  logic [3:0]    grant_index;
  logic          issue_valid;
  logic [3:0]    issue_index;
  logic [1:0]    issue_fu;
  logic          issue_ready;
`ifdef ISSUE_SELECT_STATS_EN
  logic [31:0]   stat_grants;
  logic [31:0]   stat_stalls;
`endif

  issue_select #(.RS_ENTRIES(N), .NUM_FUS(NF), .OCC_W(OW)) dut (
    .clk            (clk),
    .rst            (rst),
    .request_vector (request_vector),
    .entry_fu       (entry_fu),
    .entry_occ      (entry_occ),
    .flush          (flush),
    .grant_en       (grant_en),
    .grant_index    (grant_index),
    .issue_valid    (issue_valid),
    .issue_index    (issue_index),
    .issue_fu       (issue_fu),
    .issue_ready    (issue_ready)
`ifdef ISSUE_SELECT_STATS_EN
    ,
    .stat_grants    (stat_grants),
    .stat_stalls    (stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_rr, m_iv, m_idx, m_fu, m_last;
  int m_busy [NF];          // remaining busy cycles per FU
  int unsigned m_grants, m_stalls;
  bit m_eg;
  int m_w;

  function automatic int fu_of(input int j);
    logic [N*FW-1:0] v;
    v = entry_fu;
    return int'(v[j*FW +: FW]);
  endfunction

  function automatic int occ_of(input int j);
    logic [N*OW-1:0] v;
    v = entry_occ;
    return int'(v[j*OW +: OW]);
  endfunction

  task automatic model_reset();
    m_rr = 0; m_iv = 0; m_idx = 0; m_fu = 0; m_last = 0;
    for (int f = 0; f < NF; f++) m_busy[f] = 0;
    m_grants = 0; m_stalls = 0;
  endtask

  // One cycle: apply the inputs, compare at negedge, advance the model at posedge.
  task automatic step(input logic [N-1:0] req, input bit rdy, input bit fl,
                      output logic g, output logic [3:0] gi,
                      output logic iv, output logic [3:0] ii);
    bit found;
    request_vector = req;
    issue_ready    = rdy;
    flush          = fl;
    @(negedge clk);
    found = 0;
    m_w   = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (!found && req[j] && m_busy[fu_of(j)] == 0) begin
        found = 1;
        m_w   = j;
      end
    end
    m_eg = !rst && !fl && (m_iv == 0 || rdy) && found;
    check("grant_en",    32'(grant_en),    32'(m_eg));
    check("grant_index", 32'(grant_index), 32'(m_eg ? m_w : m_last));
    check("issue_valid", 32'(issue_valid), 32'(m_iv));
    check("issue_index", 32'(issue_index), 32'(m_idx));
    check("issue_fu",    32'(issue_fu),    32'(m_fu));
`ifdef ISSUE_SELECT_STATS_EN
    check("stat_grants", stat_grants, m_grants);
    check("stat_stalls", stat_stalls, m_stalls);
`endif
    g = grant_en; gi = grant_index; iv = issue_valid; ii = issue_index;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (m_eg) m_grants++;
      if (req != 0 && !m_eg && !fl) m_stalls++;
      if (fl) begin
        m_iv = 0;
        for (int f = 0; f < NF; f++) m_busy[f] = 0;
      end else begin
        for (int f = 0; f < NF; f++) if (m_busy[f] > 0) m_busy[f]--;
        if (m_eg) begin
          m_busy[fu_of(m_w)] = (occ_of(m_w) > 1) ? occ_of(m_w) - 1 : 0;
          m_iv = 1; m_idx = m_w; m_fu = fu_of(m_w);
          m_rr = (m_w + 1) % N; m_last = m_w;
        end else if (m_iv != 0 && rdy) begin
          m_iv = 0;
        end
      end
    end
    #1;
  endtask

  task automatic cfg_pipelined();
    for (int j = 0; j < N; j++) begin
      entry_fu[j*FW +: FW] = FW'(j % NF);
      entry_occ[j*OW +: OW] = 8'd1;
    end
  endtask

  // Two unchecked reset edges bring every flop to a known value. After that
  // comes one checked cycle with rst still high and every entry requesting,
  // so grant_en must stay low.
  task automatic do_reset();
    logic g, iv; logic [3:0] gi, ii;
    rst = 1'b1; request_vector = '0; flush = 1'b0; issue_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    step(16'hFFFF, 1'b1, 1'b0, g, gi, iv, ii);
    check("rst_grant_en", 32'(g), 32'd0);
    check("rst_issue_valid", 32'(iv), 32'd0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0] req;
    bit           rdy;
    bit           fl;
    bit           eg;
    int           egi;
    bit           eiv;
    int           eidx;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic g, iv;
    logic [3:0] gi, ii;
    int timeout_guard;
    timeout_guard = 0;

    entry_fu = '0; entry_occ = '0;
    cfg_pipelined();
    do_reset();

    // Idle after reset: no grants, slot stays empty.
    for (int c = 0; c < 5; c++) begin
      step(16'h0000, 1'b1, 1'b0, g, gi, iv, ii);
      check("idle_grant_en", 32'(g), 32'd0);
      check("idle_issue_valid", 32'(iv), 32'd0);
    end

    // Table: round-robin 0/15 alternation, drain, wrap, backpressure, flush.
    // eiv/eidx are the issue register contents seen during that cycle.
    vecs[0]  = '{16'h8001, 1, 0, 1, 0,  0, 0};
    vecs[1]  = '{16'h8001, 1, 0, 1, 15, 1, 0};
    vecs[2]  = '{16'h8001, 1, 0, 1, 0,  1, 15};
    vecs[3]  = '{16'h8001, 1, 0, 1, 15, 1, 0};
    vecs[4]  = '{16'h0000, 1, 0, 0, 15, 1, 15};
    vecs[5]  = '{16'h0004, 1, 0, 1, 2,  0, 15};
    vecs[6]  = '{16'h0005, 1, 0, 1, 0,  1, 2};
    vecs[7]  = '{16'h0005, 0, 0, 0, 0,  1, 0};
    vecs[8]  = '{16'h0005, 1, 1, 0, 0,  1, 0};
    vecs[9]  = '{16'h0005, 0, 0, 1, 2,  0, 0};
    vecs[10] = '{16'h4000, 1, 0, 1, 14, 1, 2};
    vecs[11] = '{16'h0004, 1, 0, 1, 2,  1, 14};
    for (int v = 0; v < 12; v++) begin
      step(vecs[v].req, vecs[v].rdy, vecs[v].fl, g, gi, iv, ii);
      check($sformatf("tbl%0d_grant_en", v),    32'(g),  32'(vecs[v].eg));
      check($sformatf("tbl%0d_grant_index", v), 32'(gi), 32'(vecs[v].egi));
      check($sformatf("tbl%0d_issue_valid", v), 32'(iv), 32'(vecs[v].eiv));
      check($sformatf("tbl%0d_issue_index", v), 32'(ii), 32'(vecs[v].eidx));
    end
    // The wrapped grant of entry 2 leaves rr_ptr at 3: entries 0 and 3 are
    // both requesting, and 3 must win.
    step(16'h0009, 1'b1, 1'b0, g, gi, iv, ii);
    check("wrap_issue_index", 32'(ii), 32'd2);
    check("wrap_rr_ptr_next", 32'(gi), 32'd3);

    // Backpressure: a held slot blocks grants and keeps issue_index stable.
    do_reset();
    step(16'h0008, 1'b1, 1'b0, g, gi, iv, ii);
    check("bp_first_grant", 32'(gi), 32'd3);
    for (int c = 0; c < 4; c++) begin
      step(16'h0030, 1'b0, 1'b0, g, gi, iv, ii);
      check("bp_no_grant", 32'(g), 32'd0);
      check("bp_index_held", 32'(ii), 32'd3);
    end
    step(16'h0030, 1'b1, 1'b0, g, gi, iv, ii);
    check("bp_release_grant_en", 32'(g), 32'd1);
    check("bp_release_index", 32'(gi), 32'd4);

    // Non-pipelined FU: entries 2 and 5 share FU1 with occupancy 3.
    do_reset();
    entry_fu[2*FW +: FW] = 2'd1; entry_occ[2*OW +: OW] = 8'd3;
    entry_fu[5*FW +: FW] = 2'd1; entry_occ[5*OW +: OW] = 8'd3;
    step(16'h0024, 1'b1, 1'b0, g, gi, iv, ii);
    check("np_t0_grant", 32'(gi), 32'd2);
    for (int c = 1; c < 3; c++) begin
      step(16'h0020, 1'b1, 1'b0, g, gi, iv, ii);
      check($sformatf("np_t%0d_blocked", c), 32'(g), 32'd0);
    end
    step(16'h0020, 1'b1, 1'b0, g, gi, iv, ii);
    check("np_t3_grant_en", 32'(g), 32'd1);
    check("np_t3_grant", 32'(gi), 32'd5);

    // Flush while FU1 still has two busy cycles and the slot is full.
    step(16'h0024, 1'b1, 1'b1, g, gi, iv, ii);
    check("flush_no_grant", 32'(g), 32'd0);
    step(16'h0004, 1'b0, 1'b0, g, gi, iv, ii);
    check("flush_issue_valid", 32'(iv), 32'd0);
    check("flush_fu1_free", 32'(g), 32'd1);
    check("flush_grant_index", 32'(gi), 32'd2);
    cfg_pipelined();

`ifdef ISSUE_SELECT_STATS_EN
    do_reset();
    step(16'h0004, 1'b1, 1'b0, g, gi, iv, ii);
    check("stats_one_grant", stat_grants, 32'd1);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) begin
        for (int j = 0; j < N; j++) begin
          entry_fu[j*FW +: FW] = FW'($urandom_range(0, NF - 1));
          entry_occ[j*OW +: OW] = OW'($urandom_range(0, 4));
        end
      end
      step(N'($urandom & $urandom), $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, g, gi, iv, ii);
      timeout_guard++;
    end
    check("random_cycles_run", 32'(timeout_guard), 32'd800);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
